mux_sel_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 32 +++
 rtl/rr_pick8.sv | 42 ++++
 rtl/mux_sel_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants, state type and helpers for the mux_sel_arbiter slice.
//   NUM_REQ       : number of requesters sharing the result mux
//   SEL_W         : width of the binary mux select
//   arb_state_t   : arbiter ownership state {IDLE, OWNED}
//   onehot_to_idx : converts a one-hot vector to its binary bit index
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // OR-combines the indices of all set bits; exact for a one-hot input,
  // returns 0 for an all-zero input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin picker over eight requests.
// Searches (req & mask) starting at ptr and moving upward, wrapping 7->0;
// the first set bit wins.
// Ports:
//   req   [7:0] in  : request vector
//   ptr   [2:0] in  : index with highest priority
//   mask  [7:0] in  : 1 = eligible, 0 = excluded from this decision
//   found       out : at least one eligible request
//   idx   [2:0] out : winning index (meaningful only when found)
// -----------------------------------------------------------------------------
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_first;

  // Rotate so that bit 0 of w_rot is the candidate at ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_cand = req & mask;
    w_rot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = w_cand[SEL_W'(i) + ptr];
    end
  end

  assign w_first = w_rot & (~w_rot + NUM_REQ'(1));
  assign found   = |w_cand;
  // Undo the rotation; the 3-bit add wraps modulo 8.
  assign idx     = onehot_to_idx(w_first) + ptr;

endmodule

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin arbiter sharing the 8:1 result mux among eight requesters.
// One owner at a time; ownership lasts while the owner's level request
// stays high. On release the next owner is picked in the same cycle and
// granted on the next edge with no idle bubble. All outputs are registered.
//
// Optional feature (macro ARB_TIMEOUT_EN): ownership is bounded to MAX_HOLD
// cycles; on expiry the owner is revoked as if it had released, and
// `timeout` pulses for one cycle together with the new grant value.
// Without the macro there is no hold counter and `timeout` stays 0.
//
// Parameters:
//   MAX_HOLD      : max ownership cycles (1..255), ARB_TIMEOUT_EN only
// Ports:
//   clk           in  : clock, rising edge
//   rst_n         in  : asynchronous active-low reset
//   req     [7:0] in  : level requests, bit i = requester i
//   gnt     [7:0] out : one-hot grant, zero when no owner
//   sel     [2:0] out : binary owner index, held while idle
//   busy          out : high while a grant is asserted
//   timeout       out : one-cycle pulse on forced revocation
// -----------------------------------------------------------------------------
module mux_sel_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_sel_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;

  logic [NUM_REQ-1:0] w_mask;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic               w_release;
  logic               w_expire;
  logic               w_decide;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]         r_hold_cnt;
  logic [7:0]         w_hold_cnt_nxt;
`endif

  // The current owner is masked out so a release or revocation always
  // hands over to someone else; when idle everyone is eligible.
  assign w_mask    = (r_state == OWNED) ? ~(NUM_REQ'(1) << r_sel) : '1;
  assign w_release = (r_state == OWNED) && !req[r_sel];

`ifdef ARB_TIMEOUT_EN
  // r_hold_cnt counts completed hold cycles, so the current OWNED cycle is
  // number r_hold_cnt+1; expiry at MAX_HOLD gives exactly MAX_HOLD cycles.
  assign w_expire  = (r_state == OWNED) && req[r_sel] &&
                     ((9'(r_hold_cnt) + 9'd1) == 9'(MAX_HOLD));
`else
  assign w_expire  = 1'b0;
`endif

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .mask  (w_mask),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_decide      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
`endif

    case (r_state)
      IDLE: begin
        w_decide = 1'b1;
      end
      OWNED: begin
        if (w_release || w_expire) begin
          w_decide      = 1'b1;
          w_timeout_nxt = w_expire;
        end
`ifdef ARB_TIMEOUT_EN
        if (!w_release && !w_expire) begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_decide = 1'b1;
      end
    endcase

    if (w_decide) begin
      if (w_found) begin
        w_state_nxt = OWNED;
        w_gnt_nxt   = NUM_REQ'(1) << w_idx;
        w_sel_nxt   = w_idx;
        w_ptr_nxt   = w_idx + SEL_W'(1);
        w_busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt = '0;
`endif
      end else begin
        // sel keeps its last value so the shared mux output stays stable.
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`endif

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter: a round-robin vector table,
// hand-written multi-cycle sequences, and randomized requests checked
// against an owner/pointer reference model.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = nobody), priority pointer, last
  // select, completed hold cycles, and the expected timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_cnt   = 0;
  int m_to    = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[9];

  mux_sel_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_cnt   = 0;
    m_to    = 0;
  endtask

  // One rising edge of the specified behaviour, given the sampled requests.
  task automatic model_step(input logic [7:0] r);
    int decide;
    int excl;
    int winner;
    int c;
    decide = 0;
    excl   = -1;
    m_to   = 0;
    if (m_owner < 0) begin
      decide = 1;
    end else if (!r[m_owner]) begin
      decide = 1;
      excl   = m_owner;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_cnt + 1 >= int'(TB_MAX_HOLD)) begin
      decide = 1;
      excl   = m_owner;
      m_to   = 1;
    end
`endif
    else begin
      m_cnt++;
    end
    if (decide != 0) begin
      winner = -1;
      for (int k = 0; k < 8; k++) begin
        c = (m_ptr + k) % 8;
        if (winner < 0 && c != excl && r[c]) winner = c;
      end
      if (winner >= 0) begin
        m_owner = winner;
        m_sel   = winner;
        m_ptr   = (winner + 1) % 8;
        m_cnt   = 0;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_gnt;
    e_gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    chk({tag, ".sel"},     32'(sel),     32'(m_sel));
    chk({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step(req);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req   = r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt",     32'(gnt),     32'h0);
    chk("rst.sel",     32'(sel),     32'h0);
    chk("rst.busy",    32'(busy),    32'h0);
    chk("rst.timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // Round-robin order from reset: 0 first, then one-cycle owners 1..7,0.
    tbl[0] = '{req: 8'hFF, gnt: 8'h01, sel: 3'd0, busy: 1'b1};
    for (int k = 1; k < 8; k++) begin
      tbl[k] = '{req: ~(8'h01 << (k - 1)), gnt: 8'h01 << k, sel: 3'(k), busy: 1'b1};
    end
    tbl[8] = '{req: 8'h7F, gnt: 8'h01, sel: 3'd0, busy: 1'b1};

    apply_reset(8'hFF);
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req;
      @(posedge clk);
      model_step(req);
      #1;
      chk($sformatf("tbl%0d.gnt", i),  32'(gnt),  32'(tbl[i].gnt));
      chk($sformatf("tbl%0d.sel", i),  32'(sel),  32'(tbl[i].sel));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // ptr=5 with requests 7 and 4: 7 wins, then 4 with no idle cycle.
    apply_reset(8'h00);
    req = 8'h10; step("p5.a");
    req = 8'h00; step("p5.b");
    req = 8'h90; step("p5.c");
    chk("p5.gnt7", 32'(gnt), 32'h80);
    step("p5.d");
    req = 8'h10; step("p5.e");
    chk("p5.gnt4", 32'(gnt), 32'h10);
    chk("p5.busy", 32'(busy), 32'h1);

    // Single requester 3 for four cycles, then idle with sel held at 3.
    apply_reset(8'h00);
    cnt = 0;
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      step("r3.hold");
      if (gnt == 8'h08) cnt++;
    end
    req = 8'h00;
    step("r3.rel");
    if (gnt == 8'h08) cnt++;
    step("r3.idle");
    chk("r3.cycles", 32'(cnt),  32'd4);
    chk("r3.gnt0",   32'(gnt),  32'h0);
    chk("r3.busy0",  32'(busy), 32'h0);
    chk("r3.sel3",   32'(sel),  32'd3);

    // Asynchronous reset between edges while requester 4 owns the mux.
    apply_reset(8'h00);
    req = 8'h10;
    step("ar.grant");
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.gnt",  32'(gnt),  32'h0);
    chk("ar.busy", 32'(busy), 32'h0);
    chk("ar.sel",  32'(sel),  32'h0);

`ifdef ARB_TIMEOUT_EN
    // Requesters 2 and 6 held: 2 revoked after MAX_HOLD cycles, 6 takes over.
    apply_reset(8'h44);
    step("to.grant");
    chk("to.gnt2", 32'(gnt), 32'h04);
    cnt = 0;
    for (int i = 0; i < int'(TB_MAX_HOLD); i++) begin
      step("to.hold");
      if (timeout) cnt++;
    end
    chk("to.gnt6",  32'(gnt),     32'h40);
    chk("to.pulse", 32'(timeout), 32'h1);
    step("to.after");
    if (timeout) cnt++;
    chk("to.count", 32'(cnt), 32'd1);
`else
    // Requester 1 held for 300 cycles: ownership is never revoked.
    apply_reset(8'h02);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step("long");
      if (gnt != 8'h02 || timeout) cnt++;
    end
    chk("long.drops", 32'(cnt), 32'd0);
`endif

    // Randomized level requests against the reference model.
    apply_reset(8'h00);
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      step($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
